acc_op_sequencer: RTL
=====================

# acc_op_sequencer

Controller that sequences the 16-bit accumulator register (ACC) of the calculator datapath. It accepts one operation at a time over a valid/ready handshake and computes the new accumulator value from the ACC output and a supplied operand. It drives the ACC write port and reports completion and Z/C flags. Single-cycle ALU ops and a 16-iteration shift-add multiply share one ACC write path.

## Interface
Parameters:
- WIDTH, 16, datapath and ACC width; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  3  opcode: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 MUL.
- req_operand  in  WIDTH  operand B.
- acc_out  in  WIDTH  current ACC value, operand A.
- acc_in  out  WIDTH  value presented to ACC data input.
- acc_w  out  1  ACC write enable; ACC captures acc_in on the next rising clk.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, high in DONE state.
- flag_z  out  1  last written result was zero.
- flag_c  out  1  carry, borrow or multiply overflow of the last written result.

## Operation
- States: IDLE, EXEC, MUL, WB, DONE.
- Accept: req_valid && req_ready at a rising edge. At that edge the sequencer latches op, latches B = req_operand and snapshots A = acc_out. Later input changes are ignored until the next accept.
- IDLE -> DONE for NOP. IDLE -> MUL for MUL. IDLE -> EXEC for all other ops.
- EXEC: acc_w=1, acc_in=result. Flags update at the same edge. Next state is DONE.
  - LOAD: result=B, c=0.
  - ADD: result=A+B, c=carry out of bit WIDTH-1.
  - SUB: result=A-B, c=1 when B>A (unsigned borrow).
  - AND/OR/XOR: bitwise result, c=0.
- MUL: 2*WIDTH-bit product register P cleared at accept. 4-bit counter cnt starts at 0. Each cycle, if bit cnt of B is 1, P += A<<cnt. After the iteration with cnt=15 the state goes to WB. Exactly 16 iteration edges.
- WB: acc_w=1, acc_in=P[WIDTH-1:0]. c=|P[2*WIDTH-1:WIDTH]. Next state is DONE.
- DONE: done=1, acc_w=0. Next state is IDLE.
- flag_z = (written result == 0). Both flags update only on an edge where acc_w=1 and hold otherwise. NOP leaves flags unchanged.
- acc_w=0 and acc_in=0 in every state except EXEC and WB.
- Requests arriving while busy are not accepted (req_ready=0). The requester holds req_valid until accepted.

## Timing
- Reset (asynchronous, immediate): state=IDLE, req_ready=1, busy=0, done=0, acc_w=0, acc_in=0, flag_z=0, flag_c=0, cnt=0, P=0.
- Reset in mid-operation aborts the op with no ACC write. If rst asserts during EXEC or WB, acc_w drops immediately and the write is lost. The ACC value itself is not affected by this reset.
- Edge numbering: accept at edge E0.
  - NOP: DONE in cycle E0–E1, IDLE after E1.
  - Single-cycle op: EXEC in E0–E1, ACC written at E1. done is high E1–E2. req_ready is high again after E2. Throughput is one op per 3 cycles.
  - MUL: iterations at E1..E16, WB in E16–E17, ACC written at E17. done is high E17–E18. IDLE after E18.
- Back-to-back: with req_valid held high, the next accept occurs at the first edge in IDLE. A is then the freshly written ACC value.
- Outputs are Moore-decoded from registered state. No combinational path runs from req_* to acc_w/acc_in.

## Test plan
- Reset then LOAD 0x6AB3: acc_w high exactly one cycle (E0–E1) with acc_in=0x6AB3. Then done pulse, z=0, c=0, req_ready back high after E2.
- Back-to-back ADD: with ACC=0x6AB3, ADD 0x0800 gives acc_in=0x72B3, c=0. Then with ACC=0xFFFF, ADD 0x0001 gives acc_in=0x0000, z=1, c=1.
- SUB 0x72B4 with ACC=0x72B3: acc_in=0xFFFF, c=1, z=0. XOR 0xFFFF with ACC=0xFFFF: acc_in=0x0000, z=1, c=0.
- MUL 0x0010 with ACC=0x0F00: acc_w only at E16–E17 with acc_in=0xF000, c=0, done at E17–E18. MUL 0x0100 with ACC=0x0F00: acc_in=0x0000, z=1, c=1.
- Assert rst during the MUL iteration at cnt=5: acc_w never rises, busy/done=0 immediately, flags=0, and a new LOAD accepted after deassert completes normally.
- req_valid asserted while busy: no accept and no change to latched op/B. The request is accepted in the first IDLE cycle. A NOP issued there pulses done after one edge and leaves flags unchanged.

Source files
------------

// File: rtl/acc_op_sequencer.sv
// Accumulator operation sequencer: accepts one op over valid/ready, computes the
// new ACC value from a snapshot of acc_out and a latched operand, and drives the
// ACC write port. MUL runs a 16-iteration shift-add before a single write-back.
module acc_op_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_operand,
  input  logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] acc_in,
  output logic             acc_w,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpLoad = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpOr   = 3'b101;
  localparam logic [2:0] OpXor  = 3'b110;
  localparam logic [2:0] OpMul  = 3'b111;

  typedef enum logic [2:0] {StIdle, StExec, StMul, StWb, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CntW-1:0]    cnt_q;
  logic               z_q, c_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_c;
  logic               wr_c;
  logic               accept;

  assign accept    = (state_q == StIdle) && req_valid;
  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign flag_z    = z_q;
  assign flag_c    = c_q;

  // Single-cycle ALU on the latched operands; only consumed in EXEC.
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    exec_res = '0;
    exec_c   = 1'b0;
    unique case (op_q)
      OpLoad: exec_res = b_q;
      OpAdd: begin
        exec_res = sum[WIDTH-1:0];
        exec_c   = sum[WIDTH];
      end
      OpSub: begin
        exec_res = a_q - b_q;
        exec_c   = (b_q > a_q);
      end
      OpAnd:   exec_res = a_q & b_q;
      OpOr:    exec_res = a_q | b_q;
      OpXor:   exec_res = a_q ^ b_q;
      OpNop, OpMul: exec_res = '0;
    endcase
  end

  // Next state and Moore-decoded ACC write port.
  always_comb begin
    state_d = state_q;
    acc_w   = 1'b0;
    acc_in  = '0;
    wr_c    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_op == OpNop)      state_d = StDone;
          else if (req_op == OpMul) state_d = StMul;
          else                      state_d = StExec;
        end
      end
      StExec: begin
        acc_w   = 1'b1;
        acc_in  = exec_res;
        wr_c    = exec_c;
        state_d = StDone;
      end
      StMul: begin
        if (cnt_q == CntMax) state_d = StWb;
      end
      StWb: begin
        acc_w   = 1'b1;
        acc_in  = p_q[WIDTH-1:0];
        wr_c    = |p_q[2*WIDTH-1:WIDTH];
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Operand latches, multiply accumulator and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OpNop;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= req_op;
        a_q   <= acc_out;
        b_q   <= req_operand;
        p_q   <= '0;
        cnt_q <= '0;
      end
      if (state_q == StMul) begin
        if (b_q[cnt_q]) p_q <= p_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
        cnt_q <= cnt_q + CntW'(1);
      end
      // Flags follow only actual ACC writes, so NOP and aborted ops leave them alone.
      if (acc_w) begin
        z_q <= (acc_in == '0);
        c_q <= wr_c;
      end
    end
  end

endmodule
